// File: rtl/rf_channel_scheduler.sv
// Half-duplex air-channel scheduler: arbitrates the shared RF front end between
// transmit (preamble, payload, guard) and receive (grant, completion/timeout, guard).
module rf_channel_scheduler #(
    parameter int PREAMBLE_NORMAL = 16,
    parameter int PREAMBLE_WAKEUP = 2000,
    parameter int GUARD_CYCLES    = 32,
    parameter int RX_TIMEOUT      = 5000
) (
    input  logic internal_clk,
    input  logic rst_n,
    input  logic M0_sync,
    input  logic M1_sync,
    input  logic AUX_mode_ctrl,
    input  logic tx_req,
    input  logic tx_done,
    input  logic rx_detect,
    input  logic rx_done,
    output logic rf_tx_en,
    output logic rf_rx_en,
    output logic preamble_active,
    output logic tx_grant,
    output logic rx_grant,
    output logic rx_abort,
    output logic AUX_state_ctrl
);

    localparam int MAX_PG     = (PREAMBLE_WAKEUP > GUARD_CYCLES) ? PREAMBLE_WAKEUP : GUARD_CYCLES;
    localparam int MAX_CYCLES = (MAX_PG > RX_TIMEOUT) ? MAX_PG : RX_TIMEOUT;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] PRE_NORMAL_LOAD = CNT_W'(PREAMBLE_NORMAL - 1);
    localparam logic [CNT_W-1:0] PRE_WAKEUP_LOAD = CNT_W'(PREAMBLE_WAKEUP - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD      = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_LAST         = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

    typedef enum logic [2:0] {
        S_SLEEP,
        S_IDLE,
        S_PREAMBLE,
        S_TX,
        S_RX,
        S_GUARD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic rfTxEn_q, rfTxEn_d;
    logic rfRxEn_q, rfRxEn_d;
    logic preamble_q, preamble_d;
    logic txGrant_q, txGrant_d;
    logic rxGrant_q, rxGrant_d;
    logic rxAbort_q, rxAbort_d;
    logic auxState_q, auxState_d;

    logic [1:0] mode;
    logic       stopReq;

    assign mode    = {M1_sync, M0_sync};
    // Mode 3 or a mode switch in progress forces the channel to sleep at safe points.
    assign stopReq = (mode == 2'd3) || !AUX_mode_ctrl;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        txGrant_d = 1'b0;
        rxAbort_d = 1'b0;

        case (state_q)
            S_SLEEP: begin
                if (!stopReq) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (stopReq) begin
                    state_d = S_SLEEP;
                end else if (rx_detect) begin
                    state_d = S_RX;
                    count_d = '0;
                end else if (tx_req && (mode != 2'd2)) begin
                    state_d = S_PREAMBLE;
                    count_d = (mode == 2'd1) ? PRE_WAKEUP_LOAD : PRE_NORMAL_LOAD;
                end
            end
            S_PREAMBLE: begin
                if (count_q == '0) begin
                    state_d   = S_TX;
                    txGrant_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            S_TX: begin
                if (tx_done) begin
                    state_d = S_GUARD;
                    count_d = GUARD_LOAD;
                end
            end
            S_RX: begin
                // Completion wins over timeout when both land in the same cycle.
                if (rx_done) begin
                    state_d = S_GUARD;
                    count_d = GUARD_LOAD;
                end else if (count_q == RX_LAST) begin
                    state_d   = S_GUARD;
                    count_d   = GUARD_LOAD;
                    rxAbort_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            S_GUARD: begin
                if (count_q == '0) begin
                    state_d = stopReq ? S_SLEEP : S_IDLE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_SLEEP;
                count_d = '0;
            end
        endcase

        rfTxEn_d   = (state_d == S_PREAMBLE) || (state_d == S_TX);
        rfRxEn_d   = (state_d == S_IDLE) || (state_d == S_RX);
        preamble_d = (state_d == S_PREAMBLE);
        rxGrant_d  = (state_d == S_RX);
        auxState_d = ((state_d == S_IDLE) || (state_d == S_SLEEP)) && !tx_req;
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SLEEP;
            count_q    <= '0;
            rfTxEn_q   <= 1'b0;
            rfRxEn_q   <= 1'b0;
            preamble_q <= 1'b0;
            txGrant_q  <= 1'b0;
            rxGrant_q  <= 1'b0;
            rxAbort_q  <= 1'b0;
            auxState_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rfTxEn_q   <= rfTxEn_d;
            rfRxEn_q   <= rfRxEn_d;
            preamble_q <= preamble_d;
            txGrant_q  <= txGrant_d;
            rxGrant_q  <= rxGrant_d;
            rxAbort_q  <= rxAbort_d;
            auxState_q <= auxState_d;
        end
    end

    assign rf_tx_en        = rfTxEn_q;
    assign rf_rx_en        = rfRxEn_q;
    assign preamble_active = preamble_q;
    assign tx_grant        = txGrant_q;
    assign rx_grant        = rxGrant_q;
    assign rx_abort        = rxAbort_q;
    assign AUX_state_ctrl  = auxState_q;

endmodule

// File: tb/tb_rf_channel_scheduler.sv
// Scoreboard bench for rf_channel_scheduler: each transaction predicts the output
// waveform as runs of {vector, length}; a monitor compresses DUT outputs and compares.
module tb_rf_channel_scheduler;

    localparam int PN     = 16;
    localparam int PW     = 2000;
    localparam int GUARD  = 32;
    localparam int RX_TO  = 5000;

    // Output vector bits: {rf_tx_en, rf_rx_en, preamble_active, tx_grant, rx_grant, rx_abort, AUX_state_ctrl}
    localparam logic [6:0] V_PRE   = 7'b1010000;
    localparam logic [6:0] V_TXG   = 7'b1001000;
    localparam logic [6:0] V_TX    = 7'b1000000;
    localparam logic [6:0] V_GUARD = 7'b0000000;
    localparam logic [6:0] V_ABORT = 7'b0000010;
    localparam logic [6:0] V_RX    = 7'b0100100;
    localparam logic [6:0] V_RESET = 7'b0000001;

    logic internal_clk = 1'b0;
    logic rst_n;
    logic M0_sync, M1_sync, AUX_mode_ctrl;
    logic tx_req, tx_done, rx_detect, rx_done;
    logic rf_tx_en, rf_rx_en, preamble_active, tx_grant, rx_grant, rx_abort, AUX_state_ctrl;

    typedef struct {
        logic [6:0] vec;
        int         len;
    } run_t;

    run_t       expQ[$];
    int         tests = 0;
    int         fails = 0;
    bit         monOn = 1'b0;
    logic [6:0] curVec;
    int         runLen = 0;

    rf_channel_scheduler #(
        .PREAMBLE_NORMAL(PN),
        .PREAMBLE_WAKEUP(PW),
        .GUARD_CYCLES(GUARD),
        .RX_TIMEOUT(RX_TO)
    ) dut (
        .internal_clk(internal_clk),
        .rst_n(rst_n),
        .M0_sync(M0_sync),
        .M1_sync(M1_sync),
        .AUX_mode_ctrl(AUX_mode_ctrl),
        .tx_req(tx_req),
        .tx_done(tx_done),
        .rx_detect(rx_detect),
        .rx_done(rx_done),
        .rf_tx_en(rf_tx_en),
        .rf_rx_en(rf_rx_en),
        .preamble_active(preamble_active),
        .tx_grant(tx_grant),
        .rx_grant(rx_grant),
        .rx_abort(rx_abort),
        .AUX_state_ctrl(AUX_state_ctrl)
    );

    always #5 internal_clk = ~internal_clk;

    function automatic logic [6:0] obs();
        return {rf_tx_en, rf_rx_en, preamble_active, tx_grant, rx_grant, rx_abort, AUX_state_ctrl};
    endfunction

    function automatic logic [6:0] idleVec();
        return {6'b010000, ~tx_req};
    endfunction

    function automatic logic [6:0] sleepVec();
        return {6'b000000, ~tx_req};
    endfunction

    // Compares one completed output run against the oldest prediction.
    task automatic checkOutput(input logic [6:0] v, input int n);
        run_t e;
        tests++;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL run_unexpected: got vec=%b len=%0d, required no further runs", v, n);
        end else begin
            e = expQ.pop_front();
            if (e.vec !== v || e.len != n) begin
                fails++;
                $display("[TB] FAIL run_check at %0t: got vec=%b len=%0d, required vec=%b len=%0d",
                         $time, v, n, e.vec, e.len);
            end
        end
    endtask

    task automatic checkDirect(input string name, input logic [6:0] got, input logic [6:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    always @(negedge internal_clk) begin
        if (monOn) begin
            if (runLen == 0) begin
                curVec = obs();
                runLen = 1;
            end else if (obs() === curVec) begin
                runLen++;
            end else begin
                checkOutput(curVec, runLen);
                curVec = obs();
                runLen = 1;
            end
        end
    end

    task automatic pushRun(input logic [6:0] v, input int n);
        run_t r;
        if (n > 0) begin
            if (expQ.size() > 0 && expQ[expQ.size()-1].vec == v) begin
                r = expQ.pop_back();
                r.len += n;
            end else begin
                r.vec = v;
                r.len = n;
            end
            expQ.push_back(r);
        end
    endtask

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic setMode(input logic [1:0] m);
        {M1_sync, M0_sync} = m;
    endtask

    task automatic idleCycles(input int n);
        pushRun(idleVec(), n);
        repeat (n) tick();
    endtask

    task automatic sleepCycles(input int n);
        pushRun(sleepVec(), n);
        repeat (n) tick();
    endtask

    // One transmission from IDLE: preamble, grant, payload of d+1 cycles, guard.
    task automatic doTx(input logic [1:0] m, input int d, input bit stray, input bit toSleep);
        int plen;
        plen = (m == 2'd1) ? PW : PN;
        pushRun(V_PRE, plen);
        pushRun(V_TXG, 1);
        pushRun(V_TX, d);
        pushRun(V_GUARD, GUARD);
        setMode(m);
        tx_req = 1'b1;
        tick();
        if (stray) tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (plen - 1) tick();
        tx_req = 1'b0;
        if (toSleep) setMode(2'd3);
        if (stray) begin
            rx_detect = 1'b1;
            rx_done   = 1'b1;
        end
        repeat (d) tick();
        rx_detect = 1'b0;
        rx_done   = 1'b0;
        tx_done   = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (GUARD - 1) tick();
    endtask

    // One reception from IDLE; doneAt >= RX_TO means no rx_done ever arrives.
    task automatic doRx(input int doneAt, input bit withTx, input bit holdDetect, input bit auxDrop);
        bit timedOut;
        int rxLen;
        timedOut = (doneAt >= RX_TO);
        rxLen    = timedOut ? RX_TO : doneAt + 1;
        pushRun(V_RX, rxLen);
        if (timedOut) begin
            pushRun(V_ABORT, 1);
            pushRun(V_GUARD, GUARD - 1);
        end else begin
            pushRun(V_GUARD, GUARD);
        end
        rx_detect = 1'b1;
        if (withTx) tx_req = 1'b1;
        tick();
        if (!holdDetect) rx_detect = 1'b0;
        if (auxDrop) AUX_mode_ctrl = 1'b0;
        repeat (rxLen - 1) tick();
        rx_detect     = 1'b0;
        AUX_mode_ctrl = 1'b1;
        if (!timedOut) rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (GUARD - 1) tick();
    endtask

    task automatic applyStimulus(input int op);
        logic [1:0] rxMode;
        bit         withTx;
        case (op)
            0: begin
                doTx(2'd0, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0);
                idleCycles(int'($urandom_range(1, 4)));
            end
            1: begin
                rxMode = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0;
                withTx = 1'($urandom_range(0, 1));
                setMode(rxMode);
                doRx(int'($urandom_range(0, 40)), withTx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (withTx && rxMode == 2'd0) begin
                    idleCycles(1);
                    doTx(2'd0, int'($urandom_range(0, 8)), 1'b0, 1'b0);
                    idleCycles(1);
                end else if (withTx) begin
                    idleCycles(int'($urandom_range(1, 4)));
                    tx_req = 1'b0;
                    setMode(2'd0);
                    idleCycles(1);
                end else begin
                    setMode(2'd0);
                    idleCycles(int'($urandom_range(1, 3)));
                end
            end
            2: begin
                if ($urandom_range(0, 1) != 0) setMode(2'd3);
                else AUX_mode_ctrl = 1'b0;
                sleepCycles(int'($urandom_range(1, 6)));
                setMode(2'd0);
                AUX_mode_ctrl = 1'b1;
                idleCycles(int'($urandom_range(1, 3)));
            end
            3: begin
                setMode(2'd2);
                tx_req = 1'b1;
                idleCycles(int'($urandom_range(2, 8)));
                tx_req = 1'b0;
                setMode(2'd0);
                idleCycles(1);
            end
            4: begin
                doTx(2'd0, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1);
                sleepCycles(int'($urandom_range(1, 4)));
                setMode(2'd0);
                idleCycles(2);
            end
            default: begin
                tx_done = 1'b1;
                rx_done = 1'b1;
                idleCycles(1);
                tx_done = 1'b0;
                rx_done = 1'b0;
                idleCycles(int'($urandom_range(1, 3)));
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        AUX_mode_ctrl = 1'b1;
        tx_req        = 1'b0;
        tx_done       = 1'b0;
        rx_detect     = 1'b0;
        rx_done       = 1'b0;
        setMode(2'd0);
        repeat (3) @(posedge internal_clk);
        #1;
        checkDirect("reset_outputs", obs(), V_RESET);

        // Released reset: one SLEEP cycle, then IDLE with the receiver on.
        rst_n  = 1'b1;
        runLen = 0;
        monOn  = 1'b1;
        pushRun(sleepVec(), 1);
        idleCycles(6);

        doTx(2'd0, 3, 1'b0, 1'b0);
        idleCycles(4);
        doTx(2'd1, 0, 1'b1, 1'b0);
        idleCycles(3);

        setMode(2'd2);
        tx_req = 1'b1;
        idleCycles(20);
        tx_req = 1'b0;
        setMode(2'd0);
        idleCycles(3);

        doRx(10, 1'b1, 1'b0, 1'b0);
        idleCycles(1);
        doTx(2'd0, 5, 1'b0, 1'b0);
        idleCycles(3);

        doRx(RX_TO, 1'b0, 1'b0, 1'b0);
        idleCycles(3);
        doRx(RX_TO - 1, 1'b0, 1'b1, 1'b1);
        idleCycles(3);

        doTx(2'd0, 4, 1'b0, 1'b1);
        sleepCycles(5);
        setMode(2'd0);
        idleCycles(3);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 5)));
        end
        idleCycles(5);

        @(negedge internal_clk);
        #1;
        monOn = 1'b0;
        checkOutput(curVec, runLen);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_runs: got %0d unconsumed predictions, required 0", expQ.size());
        end

        // Asynchronous reset in the middle of a preamble.
        tick();
        setMode(2'd0);
        tx_req = 1'b1;
        tick();
        repeat (5) tick();
        checkDirect("preamble_before_reset", obs(), V_PRE);
        #2;
        rst_n = 1'b0;
        #1;
        checkDirect("async_reset", obs(), V_RESET);
        tx_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkDirect("idle_after_reset", obs(), 7'b0100001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
